// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for an asynchronous SRAM.
// It samples the ce_n/we_n/oe_n/addr pins on clk. Reads are answered on data_bus
// after READ_LATENCY edges. A write is committed at the end of its pulse.
// Ports:
//   clk, reset_n             system clock, async active-low reset
//   ce_n, we_n, oe_n, addr   SRAM control/address pins (inputs)
//   data_bus                 shared bidirectional data bus (Hi-Z when idle)
//   init_busy                high while the post-reset clear sweep runs
//   data_driven              high whenever data_bus is being driven
//   write_count, read_count  saturating protocol statistics
//   addr_glitch              sticky flag: addr moved during a write pulse
`timescale 1ns/1ps

module sram_responder #(
    parameter int                   ADDR_BITS    = 4,
    parameter int                   DATA_BITS    = 2,
    parameter int                   READ_LATENCY = 1,
    parameter logic [DATA_BITS-1:0] INIT_VALUE   = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce_n,
    input  logic                 we_n,
    input  logic                 oe_n,
    input  logic [ADDR_BITS-1:0] addr,
    inout  wire  [DATA_BITS-1:0] data_bus,
    output logic                 init_busy,
    output logic                 data_driven,
    output logic [15:0]          write_count,
    output logic [15:0]          read_count,
    output logic                 addr_glitch
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   clr_q, clr_d;
    logic                   clearing;

    // Previous-sample kind and address
    logic                   wr_q, rd_q;
    logic [ADDR_BITS-1:0]   ra_q;

    logic [ADDR_BITS-1:0]   hold_a_q;
    logic [DATA_BITS-1:0]   hold_d_q;

    logic [15:0]            wc_q, wc_d;
    logic [15:0]            rc_q, rc_d;
    logic                   gl_q, gl_d;

    logic                   en_q [READ_LATENCY];
    logic [ADDR_BITS-1:0]   ad_q [READ_LATENCY];

    logic [DATA_BITS-1:0]   mem [DEPTH];

    logic                   s_wr, s_rd, commit;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_wa;
    logic [DATA_BITS-1:0]   mem_wd;
    logic [DATA_BITS-1:0]   rdata;

    // Decode of the pins at this edge; we_n dominates oe_n.
    // Pins are ignored entirely while clearing.
    assign s_wr   = !clearing && !ce_n && !we_n;
    assign s_rd   = !clearing && !ce_n && we_n && !oe_n;
    assign commit = wr_q && !s_wr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        unique case (state_q)
            CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == LAST_ADDR) state_d = RUN;
            end
            RUN: ;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        init_busy = 1'b1;
        clearing  = 1'b1;
        unique case (state_q)
            CLEAR: ;
            RUN: begin
                init_busy = 1'b0;
                clearing  = 1'b0;
            end
        endcase
    end

    // ---------------- statistics next state ----------------
    always_comb begin
        wc_d = wc_q;
        rc_d = rc_q;
        gl_d = gl_q;
        if (commit && wc_q != 16'hFFFF) wc_d = wc_q + 16'd1;
        if (s_rd && !rd_q && rc_q != 16'hFFFF) rc_d = rc_q + 16'd1;
        if (s_wr && wr_q && addr != hold_a_q) gl_d = 1'b1;
    end

    // ---------------- sample, hold and statistics registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            ra_q     <= '0;
            hold_a_q <= '0;
            hold_d_q <= '0;
            wc_q     <= '0;
            rc_q     <= '0;
            gl_q     <= 1'b0;
        end else begin
            wr_q <= s_wr;
            rd_q <= s_rd;
            ra_q <= addr;
            if (s_wr) begin
                hold_a_q <= addr;
                hold_d_q <= data_bus;
            end
            wc_q <= wc_d;
            rc_q <= rc_d;
            gl_q <= gl_d;
        end
    end

    // ---------------- drive pipeline ----------------
    // Stage 0 is fed from the previous sample, so a READ sampled at
    // edge k reaches the last stage after edge k+READ_LATENCY.
    // Any non-READ sample flushes every stage at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                en_q[i] <= 1'b0;
                ad_q[i] <= '0;
            end
        end else begin
            en_q[0] <= s_rd && rd_q;
            ad_q[0] <= ra_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                en_q[i] <= s_rd && en_q[i-1];
                ad_q[i] <= ad_q[i-1];
            end
        end
    end

    // ---------------- storage array ----------------
    // Clear sweep and write commits share the single write port.
    always_comb begin
        mem_we = clearing || commit;
        mem_wa = clearing ? clr_q : hold_a_q;
        mem_wd = clearing ? INIT_VALUE : hold_d_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Combinational lookup at the output stage, so a commit that
    // lands before the data is due is seen by the read.
    assign rdata       = mem[ad_q[READ_LATENCY-1]];
    assign data_driven = en_q[READ_LATENCY-1];
    assign data_bus    = data_driven ? rdata : {DATA_BITS{1'bz}};

    assign write_count = wc_q;
    assign read_count  = rc_q;
    assign addr_glitch = gl_q;

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder: table vectors, directed corner sequences
// and randomized pin traffic against a behavioural SRAM model.
`timescale 1ns/1ps

module tb_sram_responder;

    localparam int AB  = 4;
    localparam int DB  = 2;
    localparam int LAT = 1;
    localparam int N   = 1 << AB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce_n = 1'b1;
    logic          we_n = 1'b1;
    logic          oe_n = 1'b1;
    logic [AB-1:0] addr = '0;
    logic [DB-1:0] tb_dat = '0;
    logic          tb_oe = 1'b0;
    wire  [DB-1:0] data_bus;
    logic          init_busy, data_driven, addr_glitch;
    logic [15:0]   write_count, read_count;

    assign data_bus = tb_oe ? tb_dat : {DB{1'bz}};

    always #5 clk = ~clk;

    sram_responder #(
        .ADDR_BITS(AB), .DATA_BITS(DB),
        .READ_LATENCY(LAT), .INIT_VALUE(2'b00)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ce_n(ce_n), .we_n(we_n), .oe_n(oe_n),
        .addr(addr), .data_bus(data_bus),
        .init_busy(init_busy), .data_driven(data_driven),
        .write_count(write_count), .read_count(read_count),
        .addr_glitch(addr_glitch)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: sample kinds 0=idle 1=read 2=write
    int            m_clr = 0;
    int            m_wc = 0, m_rc = 0, m_gl = 0;
    int            m_prev = 0;
    int            m_ha = 0, m_hd = 0;
    int            m_mem [N];
    int            m_hist [$];

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clr = 0; m_wc = 0; m_rc = 0; m_gl = 0;
        m_prev = 0; m_ha = 0; m_hd = 0;
        m_hist.delete();
    endtask

    // Bus is driven after an edge exactly when that sample and the
    // LAT samples before it were all READs; it shows the array value
    // at the address sampled LAT edges ago.
    function automatic bit m_drv();
        if (m_hist.size() != LAT + 1) return 1'b0;
        foreach (m_hist[i]) if (m_hist[i] < 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        int k;
        if (!reset_n) return;
        if (m_clr < N) begin
            m_mem[m_clr] = 0;
            m_clr++;
            k = 0;
        end else begin
            if (!ce_n && !we_n)      k = 2;
            else if (!ce_n && !oe_n) k = 1;
            else                     k = 0;
            if (k != 2 && m_prev == 2) begin
                m_mem[m_ha] = m_hd;
                if (m_wc < 65535) m_wc++;
            end
            if (k == 2) begin
                if (m_prev == 2 && int'(addr) != m_ha) m_gl = 1;
                m_ha = int'(addr);
                m_hd = int'(tb_dat);
            end
            if (k == 1 && m_prev != 1 && m_rc < 65535) m_rc++;
        end
        m_prev = k;
        m_hist.push_back(k == 1 ? int'(addr) : -1);
        if (m_hist.size() > LAT + 1) void'(m_hist.pop_front());
    endtask

    task automatic check_model();
        chk("busy", int'(init_busy), (m_clr < N) ? 1 : 0);
        chk("driven", int'(data_driven), int'(m_drv()));
        chk("wcount", int'(write_count), m_wc);
        chk("rcount", int'(read_count), m_rc);
        chk("glitch", int'(addr_glitch), m_gl);
        if (m_drv()) chk("bus", int'(data_bus), m_mem[m_hist[0]]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic pins(logic c, logic w, logic o, logic [AB-1:0] a, logic [DB-1:0] d);
        ce_n = c; we_n = w; oe_n = o; addr = a; tb_dat = d;
        tb_oe = !c && !w;
    endtask

    task automatic wait_clear(string nm);
        int cnt;
        cnt = 0;
        while (init_busy && cnt < 40) begin
            tick();
            cnt++;
        end
        chk(nm, cnt, N);
    endtask

    typedef struct {
        logic          ce, we, oe;
        logic [AB-1:0] a;
        logic [DB-1:0] d;
        logic          drv;
        logic [DB-1:0] bus;
        int            wc, rc;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int cnt, wc0, rc0, r;
        logic [AB-1:0] ra;

        tbl[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 5, 2, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 5, 0, 0, 0, 1, 1};
        tbl[3]  = '{0, 1, 0, 5, 0, 1, 2, 1, 1};
        tbl[4]  = '{0, 1, 0, 3, 0, 1, 2, 1, 1};
        tbl[5]  = '{0, 1, 0, 3, 0, 1, 0, 1, 1};
        tbl[6]  = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        tbl[7]  = '{0, 0, 0, 7, 1, 0, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, 7, 1, 0, 0, 1, 1};
        tbl[9]  = '{1, 1, 1, 0, 0, 0, 0, 2, 1};
        tbl[10] = '{0, 1, 0, 7, 0, 0, 0, 2, 2};
        tbl[11] = '{0, 1, 0, 7, 0, 1, 1, 2, 2};
        tbl[12] = '{1, 1, 1, 0, 0, 0, 0, 2, 2};

        // Reset state
        #1;
        chk("rst_busy", int'(init_busy), 1);
        chk("rst_drv", int'(data_driven), 0);
        chk("rst_wc", int'(write_count), 0);
        chk("rst_rc", int'(read_count), 0);
        chk("rst_gl", int'(addr_glitch), 0);
        tick();
        reset_n = 1'b1;

        // Clear sweep with pin traffic that must be ignored
        cnt = 0;
        while (init_busy && cnt < 40) begin
            if (cnt < 8)       pins(0, 1, 0, 2, 0);
            else if (cnt < 12) pins(0, 0, 1, 9, 3);
            else               pins(1, 1, 1, 0, 0);
            tick();
            cnt++;
        end
        chk("clear_len", cnt, N);
        chk("clear_counts", int'(write_count) + int'(read_count), 0);

        // Every location reads back the init value
        for (int a = 0; a < N; a++) begin
            pins(0, 1, 0, AB'(a), 0);
            tick();
            tick();
            chk("sweep_drv", int'(data_driven), 1);
            chk("sweep_val", int'(data_bus), 0);
            pins(1, 1, 1, 0, 0);
            tick();
        end

        // Table vectors: write/read, latency, release, we+oe together
        wc0 = int'(write_count);
        rc0 = int'(read_count);
        for (int i = 0; i < 13; i++) begin
            pins(tbl[i].ce, tbl[i].we, tbl[i].oe, tbl[i].a, tbl[i].d);
            tick();
            chk($sformatf("tbl%0d_drv", i), int'(data_driven), int'(tbl[i].drv));
            if (tbl[i].drv) chk($sformatf("tbl%0d_bus", i), int'(data_bus), int'(tbl[i].bus));
            chk($sformatf("tbl%0d_wc", i), int'(write_count) - wc0, tbl[i].wc);
            chk($sformatf("tbl%0d_rc", i), int'(read_count) - rc0, tbl[i].rc);
        end

        // Address moves 3 -> 4 during one write pulse
        pins(0, 0, 1, 3, 1);
        tick();
        chk("gl_before", int'(addr_glitch), 0);
        pins(0, 0, 1, 4, 3);
        tick();
        chk("gl_set", int'(addr_glitch), 1);
        pins(1, 1, 1, 0, 0);
        tick();
        pins(0, 1, 0, 3, 0);
        tick();
        tick();
        chk("gl_addr3", int'(data_bus), 0);
        pins(0, 1, 0, 4, 0);
        tick();
        tick();
        chk("gl_addr4", int'(data_bus), 3);
        pins(1, 1, 1, 0, 0);
        repeat (3) tick();
        chk("gl_sticky", int'(addr_glitch), 1);

        // Randomized traffic
        ra = 0;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 0) ra = AB'($urandom_range(0, N - 1));
            if (r < 4) begin
                pins(0, 1, 0, ra, 0);
            end else if (r < 7 && !data_driven) begin
                pins(0, 0, 1'($urandom_range(0, 1)), ra, DB'($urandom_range(0, 3)));
            end else begin
                pins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, ra, 0);
                if (!ce_n && !we_n && data_driven) pins(1, 1, 1, ra, 0);
            end
            tick();
        end

        // Reset asserted in the middle of a read, between edges
        pins(0, 1, 0, 5, 0);
        repeat (3) tick();
        chk("mid_drv_before", int'(data_driven), 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_drv", int'(data_driven), 0);
        chk("mid_busy", int'(init_busy), 1);
        chk("mid_wc", int'(write_count), 0);
        chk("mid_rc", int'(read_count), 0);
        chk("mid_gl", int'(addr_glitch), 0);
        tick();
        reset_n = 1'b1;
        wait_clear("mid_clear_len");
        repeat (3) tick();
        chk("mid_read_resume", int'(data_driven), 1);
        pins(1, 1, 1, 0, 0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
